io_bus_arbiter: RTL

IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

---
 rtl/io_bus_pkg.sv | 21 ++
 rtl/io_read_tracker.sv | 33 +++
 rtl/io_bus_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/io_bus_pkg.sv
// Shared IO bus constants and request bundle.
// Used by io_bus_arbiter and its read tracker.
package io_bus_pkg;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 16;
  localparam int CTRL_W     = 2;
  localparam int CTRL_WRITE = 1;
  localparam int CTRL_BYTE  = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [CTRL_W-1:0] ctrl;
  } io_req_t;

  function automatic logic is_read(
    input logic [CTRL_W-1:0] c
  );
    return ~c[CTRL_WRITE];
  endfunction
endpackage

// File: rtl/io_read_tracker.sv
// Outstanding-read pipeline of {valid, requester id},
// READ_LATENCY+1 deep so reads return in issue order.
module io_read_tracker #(
  parameter int READ_LATENCY = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic id_i,
  output logic rvalid0_o,
  output logic rvalid1_o
);
  logic [READ_LATENCY:0] vld_q, vld_d;
  logic [READ_LATENCY:0] id_q, id_d;

  always_comb begin
    vld_d = {vld_q[READ_LATENCY-1:0], push_i};
    id_d  = {id_q[READ_LATENCY-1:0], id_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q <= vld_d;
      id_q  <= id_d;
    end
  end

  assign rvalid0_o = vld_q[READ_LATENCY] & ~id_q[READ_LATENCY];
  assign rvalid1_o = vld_q[READ_LATENCY] &  id_q[READ_LATENCY];
endmodule

// File: rtl/io_bus_arbiter.sv
// Two-requester round-robin IO bus arbiter with registered bus drive.
// Optional bus locking is enabled by defining IO_ARB_LOCK_EN.
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int LOCK_MAX     = 16
) (
  input  logic        main_clk,
  input  logic        main_rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  input  logic [1:0]  ctrl0,
  input  logic [1:0]  ctrl1,
  input  logic        lock0,
  input  logic        lock1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [15:0] rdata,
  output logic [31:0] address_io,
  output logic [15:0] data_in_io,
  output logic [1:0]  control_io,
  input  logic [15:0] data_out_io,
  output logic        lock_abort
);
  io_req_t r0, r1, bus_q, bus_d;
  logic    ptr_q, ptr_d;
  logic    sel, any, push;

  assign r0 = {addr0, wdata0, ctrl0};
  assign r1 = {addr1, wdata1, ctrl1};

`ifdef IO_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic          lk_q, lk_d, own_q, own_d;
  logic          abort_q, abort_d, expire, lk_sel;
  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = lk_q & (cnt_q >= CW'(LOCK_MAX - 1));
  assign lk_sel = sel ? lock1 : lock0;
`else
  localparam int unused_lock_max = LOCK_MAX;
  logic unused_lock;
  assign unused_lock = lock0 ^ lock1;
`endif

  always_comb begin
    sel = ptr_q ? req1 : ~req0;
`ifdef IO_ARB_LOCK_EN
    if (lk_q) sel = own_q;
`endif
    any   = main_rst_n & (sel ? req1 : req0);
    bus_d = any ? (sel ? r1 : r0) : '0;
    ptr_d = any ? ~sel : ptr_q;
    push  = any & is_read(sel ? ctrl1 : ctrl0);
`ifdef IO_ARB_LOCK_EN
    lk_d    = lk_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    if (lk_q) begin
      cnt_d = cnt_q + CW'(1);
      if (any && !lk_sel) lk_d = 1'b0;
      // timeout wins over an owner re-lock in the same cycle
      if (expire) begin
        lk_d    = 1'b0;
        abort_d = 1'b1;
        ptr_d   = ~own_q;
      end
    end else if (any && lk_sel) begin
      lk_d  = 1'b1;
      own_d = sel;
      cnt_d = CW'(1);
    end
`endif
  end

  assign gnt0 = any & ~sel;
  assign gnt1 = any &  sel;

  always_ff @(posedge main_clk) begin
    if (!main_rst_n) begin
      ptr_q <= 1'b0;
      bus_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      bus_q <= bus_d;
    end
  end

`ifdef IO_ARB_LOCK_EN
  always_ff @(posedge main_clk) begin
    if (!main_rst_n) begin
      lk_q    <= 1'b0;
      own_q   <= 1'b0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      lk_q    <= lk_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end
  assign lock_abort = abort_q;
`else
  assign lock_abort = 1'b0;
`endif

  assign address_io = bus_q.addr;
  assign data_in_io = bus_q.wdata;
  assign control_io = bus_q.ctrl;

  io_read_tracker #(
    .READ_LATENCY(READ_LATENCY)
  ) u_trk (
    .clk_i    (main_clk),
    .rst_ni   (main_rst_n),
    .push_i   (push),
    .id_i     (sel),
    .rvalid0_o(rvalid0),
    .rvalid1_o(rvalid1)
  );

  assign rdata = (rvalid0 | rvalid1) ? data_out_io : '0;
endmodule
